// File: rtl/guarded_cmd_tx_pkg.sv
// Shared definitions for the guarded command transmitter: default word
// constants, FSM state encoding and the gap-counter width helper.
package guarded_cmd_tx_pkg;

    localparam int          CMD_W             = 32;
    localparam logic [31:0] FORBIDDEN_DEFAULT = 32'hdeadbeef;
    localparam logic [31:0] IDLE_WORD_DEFAULT = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } tx_state_e;

    // Width of a down-counter that must hold MINGAP; never narrower than 1 bit.
    function automatic int gap_width(input int mingap);
        return (mingap > 0) ? $clog2(mingap + 1) : 1;
    endfunction

endpackage

// File: rtl/guarded_cmd_tx_if.sv
// Handshake and bus signals of the guarded command transmitter.
// slave = the transmitter itself, master = upstream logic plus receiver.
interface guarded_cmd_tx_if
    import guarded_cmd_tx_pkg::*;
#(
    parameter int LGFIFO = 2
);
    logic              i_cmd_valid;
    logic [CMD_W-1:0]  i_cmd_data;
    logic              o_cmd_ready;
    logic [CMD_W-1:0]  o_word;
    logic              o_stb;
    logic              i_tx_ready;
    logic              o_reject;
    logic [LGFIFO:0]   o_fill;

    modport slave (
        input  i_cmd_valid, i_cmd_data, i_tx_ready,
        output o_cmd_ready, o_word, o_stb, o_reject, o_fill
    );

    modport master (
        output i_cmd_valid, i_cmd_data, i_tx_ready,
        input  o_cmd_ready, o_word, o_stb, o_reject, o_fill
    );
endinterface

// File: rtl/guarded_cmd_tx_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers. The head word is read
// combinationally so it can be popped into the output register in the same
// cycle the FIFO is seen non-empty.
module sync_fifo #(
    parameter int LGFIFO = 2,
    parameter int WIDTH  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LGFIFO:0]  o_fill
);
    localparam int DEPTH = 1 << LGFIFO;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LGFIFO:0]  wr_ptr_q, wr_ptr_d;
    logic [LGFIFO:0]  rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign o_full  = (wr_ptr_q[LGFIFO] != rd_ptr_q[LGFIFO]) &&
                     (wr_ptr_q[LGFIFO-1:0] == rd_ptr_q[LGFIFO-1:0]);
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_fill  = wr_ptr_q - rd_ptr_q;
    assign o_data  = mem[rd_ptr_q[LGFIFO-1:0]];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Next pointer values: advance only on a legal push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{LGFIFO{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{LGFIFO{1'b0}}, do_pop};
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q[LGFIFO-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/guarded_cmd_tx.sv
// Guarded command transmitter: filters the forbidden word at the input,
// buffers commands in a FIFO and presents them on a held, strobed bus with
// a programmable idle gap after each transfer.
// Optional reject counter enabled by defining GUARDED_CMD_REJECT_COUNT_EN.
module guarded_cmd_tx
    import guarded_cmd_tx_pkg::*;
#(
    parameter int          LGFIFO    = 2,
    parameter logic [31:0] FORBIDDEN = FORBIDDEN_DEFAULT,
    parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEFAULT,
    parameter int          MINGAP    = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
`ifdef GUARDED_CMD_REJECT_COUNT_EN
    input  logic            i_clr_count,
    output logic [15:0]     o_reject_count,
`endif
    guarded_cmd_tx_if.slave bus
);
    localparam int              GW      = gap_width(MINGAP);
    localparam logic [LGFIFO:0] DEPTH_W = (LGFIFO + 1)'(1 << LGFIFO);

    // The idle value is driven during reset, so it must never be the forbidden word.
    if (IDLE_WORD == FORBIDDEN) begin : g_bad_idle_word
        $error("guarded_cmd_tx: IDLE_WORD must differ from FORBIDDEN");
    end

    tx_state_e        state_q, state_d;
    logic [CMD_W-1:0] word_q, word_d;
    logic             stb_q, stb_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             reject_q, reject_d;
    logic             load_next;

    logic             accept, is_forbidden;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_head;
    logic [LGFIFO:0]  fifo_fill, fill_total;

    sync_fifo #(
        .LGFIFO (LGFIFO),
        .WIDTH  (CMD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (fifo_push),
        .i_data  (bus.i_cmd_data),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_fill  (fifo_fill)
    );

    // Occupancy counts the word held on the bus, so total capacity is the FIFO depth.
    assign fill_total      = fifo_fill + {{LGFIFO{1'b0}}, stb_q};
    assign bus.o_cmd_ready = !fifo_full && (fill_total != DEPTH_W);
    assign bus.o_fill      = fill_total;
    assign bus.o_word      = word_q;
    assign bus.o_stb       = stb_q;
    assign bus.o_reject    = reject_q;

    // Input filter: the forbidden word is dropped and flagged on the next cycle.
    always_comb begin
        accept       = bus.i_cmd_valid && bus.o_cmd_ready;
        is_forbidden = (bus.i_cmd_data == FORBIDDEN);
        fifo_push    = accept && !is_forbidden;
        reject_d     = accept && is_forbidden;
    end

    // FSM next state; load_next means "behave as IDLE": pop the head if there is one.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        stb_d     = stb_q;
        gap_d     = gap_q;
        fifo_pop  = 1'b0;
        load_next = 1'b0;
        case (state_q)
            IDLE: load_next = 1'b1;
            SEND: begin
                if (bus.i_tx_ready) begin
                    if (MINGAP == 0) begin
                        load_next = 1'b1;
                    end else begin
                        gap_d   = GW'(MINGAP);
                        stb_d   = 1'b0;
                        word_d  = IDLE_WORD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q <= GW'(1)) begin
                    load_next = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                word_d  = IDLE_WORD;
            end
        endcase
        if (load_next) begin
            gap_d = '0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                word_d   = fifo_head;
                stb_d    = 1'b1;
                state_d  = SEND;
            end else begin
                word_d   = IDLE_WORD;
                stb_d    = 1'b0;
                state_d  = IDLE;
            end
        end
    end

    // State, bus and reject registers; reset abandons any word in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            word_q   <= IDLE_WORD;
            stb_q    <= 1'b0;
            gap_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            stb_q    <= stb_d;
            gap_q    <= gap_d;
            reject_q <= reject_d;
        end
    end

`ifdef GUARDED_CMD_REJECT_COUNT_EN
    logic [15:0] rcount_q, rcount_d;

    // Saturating count of reject pulses; a clear always wins.
    always_comb begin
        rcount_d = rcount_q;
        if (i_clr_count) begin
            rcount_d = '0;
        end else if (reject_q && (rcount_q != 16'hffff)) begin
            rcount_d = rcount_q + 16'd1;
        end
    end

    // Reject counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rcount_q <= '0;
        end else begin
            rcount_q <= rcount_d;
        end
    end

    assign o_reject_count = rcount_q;
`endif

endmodule

// File: tb/tb_guarded_cmd_tx.sv
// Scoreboard bench for guarded_cmd_tx. Two instances (MINGAP=2 and MINGAP=0)
// share one stimulus stream; each has its own reference queue and monitor.
module tb_guarded_cmd_tx;
    import guarded_cmd_tx_pkg::*;

    localparam int          LGFIFO = 2;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] FORB   = 32'hdeadbeef;
    localparam logic [31:0] IDLEW  = 32'h00000000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data  = '0;
    logic        tx_ready  = 1'b0;
    logic        clr_count = 1'b0;

    int errors      = 0;
    int checks      = 0;
    int fail_prints = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, inst, $time, act, exp);
            end
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int MG = (gi == 0) ? 2 : 0;

        guarded_cmd_tx_if #(.LGFIFO(LGFIFO)) bus ();
        assign bus.i_cmd_valid = cmd_valid;
        assign bus.i_cmd_data  = cmd_data;
        assign bus.i_tx_ready  = tx_ready;

`ifdef GUARDED_CMD_REJECT_COUNT_EN
        logic [15:0] rcount;
`endif

        guarded_cmd_tx #(
            .LGFIFO    (LGFIFO),
            .FORBIDDEN (FORB),
            .IDLE_WORD (IDLEW),
            .MINGAP    (MG)
        ) dut (
            .i_clk          (clk),
            .i_reset        (rst),
`ifdef GUARDED_CMD_REJECT_COUNT_EN
            .i_clr_count    (clr_count),
            .o_reject_count (rcount),
`endif
            .bus            (bus)
        );

        // Reference model: queue of accepted words (head = word on the bus).
        logic [31:0] q[$];
        bit          have_exp = 1'b0;
        bit          m_stb    = 1'b0;
        bit          m_rej    = 1'b0;
        bit          nxt;
        int          lowcnt   = 1000;
        int          fifo_cnt;
        int          sz;
        logic [31:0] w;
        logic [15:0] m_cnt    = '0;

        // Monitor: compare this cycle, then predict the next one.
        always @(negedge clk) begin
            if (have_exp) begin
                check("stb", gi, 32'(bus.o_stb), 32'(m_stb));
                if (m_stb && q.size() > 0)
                    check("word_held", gi, bus.o_word, q[0]);
                else if (!m_stb)
                    check("word_idle", gi, bus.o_word, IDLEW);
                check("never_forbidden", gi, 32'(bus.o_word == FORB), 32'd0);
                check("fill", gi, 32'(bus.o_fill), 32'(q.size()));
                check("ready", gi, 32'(bus.o_cmd_ready), 32'(q.size() < DEPTH));
                check("reject", gi, 32'(bus.o_reject), 32'(m_rej));
`ifdef GUARDED_CMD_REJECT_COUNT_EN
                check("reject_count", gi, 32'(rcount), 32'(m_cnt));
`endif
            end
            if (rst) begin
                q.delete();
                m_stb    = 1'b0;
                m_rej    = 1'b0;
                lowcnt   = 1000;
                m_cnt    = '0;
                have_exp = 1'b1;
            end else if (have_exp) begin
                lowcnt   = m_stb ? 0 : ((lowcnt < 1000) ? lowcnt + 1 : lowcnt);
                sz       = q.size();
                fifo_cnt = sz - (m_stb ? 1 : 0);
                if (m_stb && !tx_ready)
                    nxt = 1'b1;
                else if (m_stb)
                    nxt = (MG == 0) && (fifo_cnt > 0);
                else
                    nxt = (fifo_cnt > 0) && (lowcnt >= MG);
                if (clr_count)
                    m_cnt = '0;
                else if (m_rej && m_cnt != 16'hffff)
                    m_cnt = m_cnt + 16'd1;
                if (m_stb && tx_ready) begin
                    w = q.pop_front();
                    $display("dut%0d xfer word=%h", gi, w);
                end
                m_rej = 1'b0;
                if (cmd_valid && sz < DEPTH) begin
                    if (cmd_data == FORB) begin
                        m_rej = 1'b1;
                        $display("dut%0d drop forbidden word", gi);
                    end else begin
                        q.push_back(cmd_data);
                    end
                end
                m_stb = nxt;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // In-order delivery with gaps.
        tx_ready = 1'b1;
        push(32'h00000001);
        push(32'h00000002);
        push(32'h00000003);
        repeat (12) step();

        // Forbidden word between two legal words.
        push(32'h11111111);
        push(FORB);
        push(32'h22222222);
        repeat (12) step();

        // Fill with receiver stalled, then keep offering a word that must be refused.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'ha0000000 + 32'(i));
        cmd_valid = 1'b1;
        cmd_data  = 32'h55555555;
        repeat (5) step();
        cmd_valid = 1'b0;

        // Reset mid-transfer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();

        // Fill again and release: back-to-back delivery on the MINGAP=0 instance.
        for (int i = 0; i < 4; i++) push(32'hb0000000 + 32'(i));
        tx_ready = 1'b1;
        repeat (15) step();

`ifdef GUARDED_CMD_REJECT_COUNT_EN
        // Three rejects, then a clear coinciding with a fourth reject pulse.
        for (int i = 0; i < 3; i++) push(FORB);
        repeat (2) step();
        push(FORB);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        repeat (2) step();
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cmd_valid = $urandom_range(0, 1) == 1;
            r         = $urandom_range(0, 7);
            cmd_data  = (r == 0) ? FORB : ((r == 1) ? 32'($urandom_range(0, 3)) : $urandom);
            tx_ready  = ($urandom_range(0, 9) < 6);
            clr_count = ($urandom_range(0, 49) == 0);
            step();
        end

        // Drain.
        rst       = 1'b0;
        cmd_valid = 1'b0;
        clr_count = 1'b0;
        tx_ready  = 1'b1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
